// File: rtl/bcd_counter_nd_if.sv
// bcd_counter_nd_if
//   Groups the control, load and status signals of the N-digit BCD counter.
//   Clock and reset stay plain ports on the counter itself.
//
//   Signal semantics: there is no handshake. Every control input is a level
//   that is sampled on each rising clk edge. count and load_err are
//   registered outputs. tc is combinational from en, up and count.
//
//   Ports (parameter DIGITS sets din/count width to 4*DIGITS):
//     en        count enable
//     up        direction, 1 = increment, 0 = decrement
//     load      synchronous parallel load
//     din       packed BCD load value, digit 0 in bits [3:0]
//     count     registered packed BCD count
//     tc        terminal count, feeds the en of the next cascaded counter
//     load_err  registered load-clamp flag
//   Modports: master drives the controls, slave is the counter.
interface bcd_counter_nd_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   din;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  load_err;

    modport master (
        output en, up, load, din,
        input  count, tc, load_err
    );

    modport slave (
        input  en, up, load, din,
        output count, tc, load_err
    );
endinterface

// File: rtl/bcd_counter_nd.sv
// bcd_counter_nd
//   Parametrised N-digit synchronous BCD up/down counter with clock enable,
//   parallel load and a terminal-count output for cascading. All digits
//   share the one clock, so there is no ripple clocking between digits.
//
//   Optional feature macro: BCD_LOAD_CHECK_EN
//     defined   : on load, any din nibble above 9 is clamped to 9, and
//                 load_err records whether any clamp happened. load_err
//                 holds until the next load or reset.
//     undefined : din loads verbatim and load_err is tied to 0.
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; count <= INIT, load_err <= 0
//     bus    bcd_counter_nd_if.slave (en, up, load, din, count, tc, load_err)
//
//   Priority on each edge: reset > load > en > hold.
module bcd_counter_nd #(
    parameter int                  DIGITS = 4,
    parameter logic [4*DIGITS-1:0] INIT   = '0
) (
    input  logic              clk,
    input  logic              reset,
    bcd_counter_nd_if.slave   bus
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]    count_q;
    logic [W-1:0]    inc_val;
    logic [W-1:0]    dec_val;
    logic [W-1:0]    load_val;

    // carry[k] is high when every digit below k is 9, so digit k steps on an
    // increment. borrow[k] is the same for all-zero digits on a decrement.
    // A non-BCD nibble is neither 9 nor 0, so it stops both chains.
    logic [DIGITS:0] carry;
    logic [DIGITS:0] borrow;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] d;
        assign d = count_q[4*k +: 4];

        assign carry[k+1]  = carry[k]  & (d == 4'd9);
        assign borrow[k+1] = borrow[k] & (d == 4'd0);

        // A digit at 9 receiving a carry rolls to 0. Any other value steps
        // by one modulo 16, so a loaded A-F advances until it wraps to 0.
        always_comb begin
            inc_val[4*k +: 4] = d;
            if (carry[k]) begin
                if (d == 4'd9) inc_val[4*k +: 4] = 4'd0;
                else           inc_val[4*k +: 4] = d + 4'd1;
            end
        end

        // A digit at 0 receiving a borrow rolls to 9. Others step down by
        // one, so a loaded A-F walks down through the binary range.
        always_comb begin
            dec_val[4*k +: 4] = d;
            if (borrow[k]) begin
                if (d == 4'd0) dec_val[4*k +: 4] = 4'd9;
                else           dec_val[4*k +: 4] = d - 4'd1;
            end
        end
    end

`ifdef BCD_LOAD_CHECK_EN
    logic [DIGITS-1:0] nib_bad;
    logic              load_err_q;

    for (genvar k = 0; k < DIGITS; k++) begin : g_clamp
        assign nib_bad[k]         = (bus.din[4*k +: 4] > 4'd9);
        assign load_val[4*k +: 4] = nib_bad[k] ? 4'd9 : bus.din[4*k +: 4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_err_q <= 1'b0;
        end else if (bus.load) begin
            load_err_q <= |nib_bad;
        end
    end

    assign bus.load_err = load_err_q;
`else
    assign load_val     = bus.din;
    assign bus.load_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= INIT;
        end else if (bus.load) begin
            count_q <= load_val;
        end else if (bus.en) begin
            count_q <= bus.up ? inc_val : dec_val;
        end
    end

    assign bus.count = count_q;

    // High in the cycle before the wrap edge. Deliberately not gated by load
    // or reset so a cascade sees a pure function of en, up and count.
    assign bus.tc = bus.en & ((bus.up & carry[DIGITS]) | (~bus.up & borrow[DIGITS]));

endmodule

// File: tb/tb_bcd_counter_nd.sv
module tb_bcd_counter_nd;

    localparam int DIGITS = 3;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        logic         rst;
        logic         ld;
        logic         en;
        logic         up;
        logic [W-1:0] din;
        logic [W-1:0] exp_count;
        logic         exp_tc;
        logic         exp_err;
    } vec_t;

    logic clk;
    logic reset;

    int n_vec;
    int n_err;

    vec_t vecs[$];

    bcd_counter_nd_if #(.DIGITS(DIGITS)) bus ();

    bcd_counter_nd #(
        .DIGITS (DIGITS),
        .INIT   (12'h000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset    = 1'b1;
        bus.en   = 1'b0;
        bus.up   = 1'b1;
        bus.load = 1'b0;
        bus.din  = '0;
    end

    // scoreboard helpers
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic rst, input logic ld, input logic en, input logic up,
                                input logic [W-1:0] din, input logic [W-1:0] ec,
                                input logic etc, input logic eerr);
        vec_t v;
        v.rst = rst; v.ld = ld; v.en = en; v.up = up; v.din = din;
        v.exp_count = ec; v.exp_tc = etc; v.exp_err = eerr;
        vecs.push_back(v);
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r[3:0]  = 4'((v % 10));
        r[7:4]  = 4'(((v / 10) % 10));
        r[11:8] = 4'(((v / 100) % 10));
        return r;
    endfunction

    // driver: inputs change at negedge, outputs sampled 1 time unit after posedge
    task automatic drive(input logic rst, input logic ld, input logic en, input logic up,
                         input logic [W-1:0] din);
        @(negedge clk);
        reset    = rst;
        bus.load = ld;
        bus.en   = en;
        bus.up   = up;
        bus.din  = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        //  rst ld en up din      count   tc err
        add(1, 0, 0, 1, 12'h000, 12'h000, 0, 0);
        add(1, 0, 0, 1, 12'h000, 12'h000, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 1, 12'h000, 12'h000, 0, 0);
        // up-count with carry into digit 2
        add(0, 1, 0, 1, 12'h098, 12'h098, 0, 0);
        add(0, 0, 1, 1, 12'h000, 12'h099, 0, 0);
        add(0, 0, 1, 1, 12'h000, 12'h100, 0, 0);
        add(0, 0, 1, 1, 12'h000, 12'h101, 0, 0);
        // wrap and tc, load wins over en
        add(0, 1, 1, 1, 12'h998, 12'h998, 0, 0);
        add(0, 0, 1, 1, 12'h000, 12'h999, 1, 0);
        add(0, 0, 1, 1, 12'h000, 12'h000, 0, 0);
        add(0, 1, 1, 0, 12'h001, 12'h001, 0, 0);
        add(0, 0, 1, 0, 12'h000, 12'h000, 1, 0);
        add(0, 0, 1, 0, 12'h000, 12'h999, 0, 0);
        // tc needs en
        add(0, 0, 0, 1, 12'h000, 12'h999, 0, 0);
        add(0, 0, 1, 0, 12'h000, 12'h998, 0, 0);
        // priority
        add(0, 1, 1, 1, 12'h555, 12'h555, 0, 0);
        add(1, 1, 1, 0, 12'h777, 12'h000, 1, 0);
        // direction flip with a frozen cycle
        add(0, 1, 0, 1, 12'h500, 12'h500, 0, 0);
        add(0, 0, 1, 1, 12'h000, 12'h501, 0, 0);
        add(0, 0, 1, 1, 12'h000, 12'h502, 0, 0);
        add(0, 0, 0, 0, 12'h000, 12'h502, 0, 0);
        add(0, 0, 1, 0, 12'h000, 12'h501, 0, 0);
        add(0, 0, 1, 0, 12'h000, 12'h500, 0, 0);
        // interior carry and borrow
        add(0, 1, 0, 1, 12'h909, 12'h909, 0, 0);
        add(0, 0, 1, 1, 12'h000, 12'h910, 0, 0);
        add(0, 1, 0, 0, 12'h100, 12'h100, 0, 0);
        add(0, 0, 1, 0, 12'h000, 12'h099, 0, 0);
`ifdef BCD_LOAD_CHECK_EN
        add(0, 1, 0, 1, 12'h9A3, 12'h993, 0, 1);
        add(0, 0, 0, 1, 12'h000, 12'h993, 0, 1);
        add(0, 1, 0, 1, 12'h123, 12'h123, 0, 0);
        add(0, 1, 0, 1, 12'h0F0, 12'h090, 0, 1);
        add(1, 0, 0, 1, 12'h000, 12'h000, 0, 0);
`else
        // non-BCD nibble: +1 mod 16, no carry out of it
        add(0, 1, 0, 1, 12'h00C, 12'h00C, 0, 0);
        add(0, 0, 1, 1, 12'h000, 12'h00D, 0, 0);
        add(0, 0, 1, 1, 12'h000, 12'h00E, 0, 0);
        add(0, 0, 1, 1, 12'h000, 12'h00F, 0, 0);
        add(0, 0, 1, 1, 12'h000, 12'h000, 0, 0);
        add(0, 1, 0, 0, 12'h00A, 12'h00A, 0, 0);
        add(0, 0, 1, 0, 12'h000, 12'h009, 0, 0);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].din);
            check($sformatf("vec%0d count", i), bus.count, vecs[i].exp_count);
            check($sformatf("vec%0d tc", i), W'(bus.tc), W'(vecs[i].exp_tc));
            check($sformatf("vec%0d load_err", i), W'(bus.load_err), W'(vecs[i].exp_err));
        end

        // full up sweep through the 999 -> 000 wrap
        drive(0, 1, 0, 1, 12'h000);
        check("sweep start", bus.count, 12'h000);
        for (int i = 1; i <= 1000; i++) begin
            drive(0, 0, 1, 1, 12'h000);
            check($sformatf("up%0d count", i), bus.count, to_bcd(i % 1000));
            check($sformatf("up%0d tc", i), W'(bus.tc), W'((i % 1000) == 999));
        end

        // full down sweep through the 000 -> 999 wrap
        for (int i = 1; i <= 1000; i++) begin
            drive(0, 0, 1, 0, 12'h000);
            check($sformatf("dn%0d count", i), bus.count, to_bcd((1000 - i) % 1000));
            check($sformatf("dn%0d tc", i), W'(bus.tc), W'(((1000 - i) % 1000) == 0));
        end

        // reset raised between edges must not act until the next edge
        drive(0, 1, 0, 1, 12'h555);
        check("pre-reset count", bus.count, 12'h555);
        reset = 1'b1;
        #3;
        check("mid-cycle reset hold", bus.count, 12'h555);
        @(posedge clk);
        #1;
        check("reset at edge", bus.count, 12'h000);
        drive(0, 0, 0, 1, 12'h000);
        check("post-reset hold", bus.count, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
